// File: rtl/host_match_if.sv
// Request/response handshake bundle between a FIX field producer and host_match.
// The master drives the lookup request and accepts the result; the slave is the lookup engine.
interface host_match_if #(
  parameter int ADDR_WIDTH       = 2,
  parameter int VALUE_DATA_WIDTH = 72,
  parameter int VALUE_SIZE       = 8
);
  logic                        req_valid;
  logic                        req_ready;
  logic [VALUE_DATA_WIDTH-1:0] req_value;
  logic [VALUE_SIZE-1:0]       req_size;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic                        rsp_match;
  logic [ADDR_WIDTH-1:0]       rsp_index;

  modport master (
    output req_valid, req_value, req_size, rsp_ready,
    input  req_ready, rsp_valid, rsp_match, rsp_index
  );

  modport slave (
    input  req_valid, req_value, req_size, rsp_ready,
    output req_ready, rsp_valid, rsp_match, rsp_index
  );
endinterface

// File: rtl/host_match.sv
// Host-address table lookup: scans every entry through the table's registered read port and
// reports the lowest-indexed entry whose size and significant bytes equal the request.
module host_match #(
  parameter int ADDR_WIDTH       = 2,
  parameter int VALUE_DATA_WIDTH = 72,
  parameter int VALUE_SIZE       = 8,
  parameter int DATA_WIDTH       = VALUE_DATA_WIDTH + VALUE_SIZE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  host_match_if.slave           bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int NBYTES = VALUE_DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SCAN  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]       cmp_idx_q, cmp_idx_d;
  logic [VALUE_DATA_WIDTH-1:0] value_q, value_d;
  logic [VALUE_SIZE-1:0]       size_q, size_d;
  logic                        match_q, match_d;
  logic [ADDR_WIDTH-1:0]       index_q, index_d;
  logic                        req_ready_q, req_ready_d;
  logic                        rsp_valid_q, rsp_valid_d;

  logic [VALUE_SIZE-1:0]       entry_size_s;
  logic [VALUE_DATA_WIDTH-1:0] entry_value_s;
  logic                        hit_s;

  // A size outside 1..NBYTES marks an unusable request or an empty table slot.
  function automatic logic size_ok(input logic [VALUE_SIZE-1:0] s);
    return (s != {VALUE_SIZE{1'b0}}) && (s <= VALUE_SIZE'(NBYTES));
  endfunction

  function automatic logic bytes_eq(input logic [VALUE_DATA_WIDTH-1:0] a,
                                    input logic [VALUE_DATA_WIDTH-1:0] b,
                                    input logic [VALUE_SIZE-1:0]       n);
    logic eq;
    eq = 1'b1;
    for (int i = 0; i < NBYTES; i++) begin
      if ((VALUE_SIZE'(i) < n) &&
          (a[VALUE_DATA_WIDTH-1-8*i -: 8] != b[VALUE_DATA_WIDTH-1-8*i -: 8])) begin
        eq = 1'b0;
      end else begin
        eq = eq;
      end
    end
    return eq;
  endfunction

  assign entry_size_s  = ram_q[VALUE_SIZE-1:0];
  assign entry_value_s = ram_q[DATA_WIDTH-1 -: VALUE_DATA_WIDTH];
  assign hit_s         = size_ok(entry_size_s) && (entry_size_s == size_q) &&
                         bytes_eq(entry_value_s, value_q, size_q);

  // Next-state and next-output computation for the scan sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmp_idx_d = cmp_idx_q;
    value_d   = value_q;
    size_d    = size_q;
    match_d   = match_q;
    index_d   = index_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          value_d = bus.req_value;
          size_d  = bus.req_size;
          cnt_d   = {ADDR_WIDTH{1'b0}};
          if (size_ok(bus.req_size)) begin
            state_d = PRIME;
          end else begin
            state_d = RESP;
            match_d = 1'b0;
            index_d = {ADDR_WIDTH{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      PRIME: begin
        cnt_d     = ADDR_WIDTH'(1);
        cmp_idx_d = {ADDR_WIDTH{1'b0}};
        state_d   = SCAN;
      end
      SCAN: begin
        // ram_q reflects cmp_idx this cycle; cnt runs one ahead and its wrapped read is unused.
        if (hit_s) begin
          state_d = RESP;
          match_d = 1'b1;
          index_d = cmp_idx_q;
        end else if (cmp_idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = RESP;
          match_d = 1'b0;
          index_d = {ADDR_WIDTH{1'b0}};
        end else begin
          cmp_idx_d = cmp_idx_q + ADDR_WIDTH'(1);
          cnt_d     = cnt_q + ADDR_WIDTH'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= {ADDR_WIDTH{1'b0}};
      cmp_idx_q   <= {ADDR_WIDTH{1'b0}};
      value_q     <= {VALUE_DATA_WIDTH{1'b0}};
      size_q      <= {VALUE_SIZE{1'b0}};
      match_q     <= 1'b0;
      index_q     <= {ADDR_WIDTH{1'b0}};
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmp_idx_q   <= cmp_idx_d;
      value_q     <= value_d;
      size_q      <= size_d;
      match_q     <= match_d;
      index_q     <= index_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign ram_addr      = cnt_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_match = match_q;
  assign bus.rsp_index = index_q;

endmodule

// File: tb/tb_host_match.sv
// Directed bench for host_match: table-driven lookups against a registered-read table model,
// plus hand-written backpressure and mid-scan reset sequences.
module tb_host_match;

  logic        clk;
  logic        reset_n;
  logic [1:0]  ram_addr;
  logic [79:0] ram_q;
  logic [79:0] mem [4];

  int n_cmp;
  int n_fail;

  host_match_if #(.ADDR_WIDTH(2), .VALUE_DATA_WIDTH(72), .VALUE_SIZE(8)) bus ();

  host_match #(.ADDR_WIDTH(2), .VALUE_DATA_WIDTH(72), .VALUE_SIZE(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_q    (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table RAM with registered address: q shows the addressed entry from the next cycle.
  always @(posedge clk) ram_q <= mem[ram_addr];

  typedef struct {
    string            name;
    logic [3:0][79:0] ent;
    logic [71:0]      value;
    logic [7:0]       size;
    logic             exp_match;
    logic [1:0]       exp_index;
    int               exp_lat;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [71:0] lj(input logic [71:0] s, input int n);
    return s << (8 * (9 - n));
  endfunction

  function automatic logic [79:0] mk(input logic [71:0] s, input int n);
    return {lj(s, n), 8'(n)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic lookup(input logic [71:0] v, input logic [7:0] s,
                        output logic m, output logic [1:0] idx, output int lat,
                        output logic [1:0] a0, output logic [1:0] a1, output logic rdy0);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_value = v;
    bus.req_size  = s;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    a0   = ram_addr;
    a1   = ram_addr;
    rdy0 = bus.req_ready;
    lat  = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) a1 = ram_addr;
    end while (!bus.rsp_valid && lat < 20);
    m   = bus.rsp_match;
    idx = bus.rsp_index;
  endtask

  task automatic handshake(input string nm);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({nm, "_post_hs_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({nm, "_post_hs_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({nm, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({nm, "_rsp_match"}, 32'(bus.rsp_match), 32'd0);
    chk({nm, "_rsp_index"}, 32'(bus.rsp_index), 32'd0);
    chk({nm, "_ram_addr"},  32'(ram_addr),      32'd0);
  endtask

  initial begin
    logic       m;
    logic [1:0] idx, a0, a1;
    logic       rdy0;
    int         lat;
    logic [79:0] order5, hostb5, empty;

    n_cmp  = 0;
    n_fail = 0;
    order5 = mk("ORDER", 5);
    hostb5 = mk("HOSTB", 5);
    empty  = 80'h0;
    for (int i = 0; i < 4; i++) mem[i] = empty;

    vecs[0] = '{"inv_size0",  {empty, empty, empty, order5}, lj("ORDER", 5), 8'd0,  1'b0, 2'd0, 1};
    vecs[1] = '{"inv_size10", {empty, empty, empty, order5}, lj("ORDER", 5), 8'd10, 1'b0, 2'd0, 1};
    vecs[2] = '{"hit_e0",     {empty, empty, empty, order5}, lj("ORDER", 5), 8'd5,  1'b1, 2'd0, 2};
    vecs[3] = '{"dup_e1",     {hostb5, empty, hostb5, order5}, lj("HOSTB", 5), 8'd5, 1'b1, 2'd1, 3};
    vecs[4] = '{"dup_e3",     {hostb5, empty, empty, order5}, lj("HOSTB", 5), 8'd5, 1'b1, 2'd3, 5};
    vecs[5] = '{"prefix",     {empty, empty, empty, mk("ORDERS", 6)},
                lj("ORDER", 5) | 72'h0000000000FFFFFFFF, 8'd5, 1'b0, 2'd0, 5};
    vecs[6] = '{"full9_e2",   {empty, mk("ABCDEFGHI", 9), empty, order5},
                lj("ABCDEFGHI", 9), 8'd9, 1'b1, 2'd2, 4};
    vecs[7] = '{"dontcare",   {mk("XY", 2), empty, {lj("XY", 2) | 72'h0000FFFFFFFFFFFFFF, 8'd2}, empty},
                lj("XY", 2), 8'd2, 1'b1, 2'd1, 3};
    vecs[8] = '{"size_short", {empty, mk("ABCDEFGHI", 9), empty, empty},
                lj("ABCDEFGHI", 9), 8'd8, 1'b0, 2'd0, 5};

    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_value = 72'h0;
    bus.req_size  = 8'd0;
    bus.rsp_ready = 1'b0;
    #12;
    chk_reset_outputs("in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("after_reset");

    for (int v = 0; v < 9; v++) begin
      for (int e = 0; e < 4; e++) mem[e] = vecs[v].ent[e];
      lookup(vecs[v].value, vecs[v].size, m, idx, lat, a0, a1, rdy0);
      chk({vecs[v].name, "_req_ready_busy"}, 32'(rdy0), 32'd0);
      chk({vecs[v].name, "_latency"}, 32'(lat), 32'(vecs[v].exp_lat));
      chk({vecs[v].name, "_match"}, 32'(m), 32'(vecs[v].exp_match));
      chk({vecs[v].name, "_index"}, 32'(idx), 32'(vecs[v].exp_index));
      chk({vecs[v].name, "_addr0"}, 32'(a0), 32'd0);
      chk({vecs[v].name, "_addr1"}, 32'(a1), (vecs[v].exp_lat == 1) ? 32'd0 : 32'd1);
      handshake(vecs[v].name);
    end

    // Backpressure: response must hold while a new request waits.
    mem[0] = order5;
    mem[1] = hostb5;
    mem[2] = empty;
    mem[3] = empty;
    lookup(lj("ORDER", 5), 8'd5, m, idx, lat, a0, a1, rdy0);
    chk("bp_first_latency", 32'(lat), 32'd2);
    bus.req_valid = 1'b1;
    bus.req_value = lj("HOSTB", 5);
    bus.req_size  = 8'd5;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_rsp_match", 32'(bus.rsp_match), 32'd1);
      chk("bp_hold_rsp_index", 32'(bus.rsp_index), 32'd0);
      chk("bp_hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_hs_req_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_second_accepted", 32'(bus.req_ready), 32'd0);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.rsp_valid && lat < 20);
    chk("bp_second_latency", 32'(lat), 32'd3);
    chk("bp_second_match", 32'(bus.rsp_match), 32'd1);
    chk("bp_second_index", 32'(bus.rsp_index), 32'd1);
    handshake("bp_second");

    // Reset while comparing entry 2 of an all-empty table.
    for (int e = 0; e < 4; e++) mem[e] = empty;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_value = lj("ORDER", 5);
    bus.req_size  = 8'd5;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_scan_addr", 32'(ram_addr), 32'd3);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("aborted_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    mem[0] = order5;
    lookup(lj("ORDER", 5), 8'd5, m, idx, lat, a0, a1, rdy0);
    chk("post_reset_latency", 32'(lat), 32'd2);
    chk("post_reset_match", 32'(m), 32'd1);
    chk("post_reset_index", 32'(idx), 32'd0);
    chk("post_reset_addr0", 32'(a0), 32'd0);
    chk("post_reset_addr1", 32'(a1), 32'd1);
    handshake("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/host_match.md
# host_match

Lookup stage directly downstream of the host-address table RAM. It accepts one parsed FIX field value (left-justified bytes plus a byte count) and scans every table entry through the RAM read port. It returns the lowest-indexed entry whose size and significant bytes match, or a miss. It is the only reader of the table's address/q port; table writes stay with the existing loader.

## Interface
Parameters:
- `ADDR_WIDTH`, default 2: table address width. DEPTH = 1 << ADDR_WIDTH = 4 entries.
- `VALUE_DATA_WIDTH`, default 72: value field width, a multiple of 8. NBYTES = VALUE_DATA_WIDTH/8 = 9.
- `VALUE_SIZE`, default 8: byte-count field width.
- `DATA_WIDTH`, default VALUE_DATA_WIDTH+VALUE_SIZE: table entry width. Layout is {value, size}. Value byte 0 is in the MSBs; bytes at index >= size are don't-care.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  lookup request valid.
- `req_ready`  out  1  block idle and able to accept a request.
- `req_value`  in  VALUE_DATA_WIDTH  field value, left-justified.
- `req_size`  in  VALUE_SIZE  number of significant bytes.
- `ram_addr`  out  ADDR_WIDTH  to the table address input. The table registers it, so q shows that entry from the following cycle.
- `ram_q`  in  DATA_WIDTH  table read data.
- `rsp_valid`  out  1  result valid; held until accepted.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_match`  out  1  1 = hit, 0 = miss.
- `rsp_index`  out  ADDR_WIDTH  index of the hit entry; 0 on a miss.

## Operation
- States are IDLE, PRIME, SCAN and RESP. The request is latched on accept: `req_valid && req_ready`.
- `req_ready` = (state == IDLE). `ram_addr` = registered address counter `cnt`. `rsp_valid` = (state == RESP).
- IDLE, on accept:
  - If req_size == 0 or req_size > NBYTES: go to RESP with miss and no scan.
  - Otherwise: cnt <= 0, go to PRIME.
- PRIME, one cycle: cnt <= 1, cmp_idx <= 0, go to SCAN.
- SCAN:
  - Each cycle, `ram_q` holds entry cmp_idx. The entry's size field is the low VALUE_SIZE bits.
  - Hit condition: entry size == latched size, and every byte i < size is equal.
  - Entries whose size is 0 or > NBYTES never hit (empty slot).
  - Hit: go to RESP, rsp_match <= 1, rsp_index <= cmp_idx.
  - Miss with cmp_idx == DEPTH-1: go to RESP, rsp_match <= 0, rsp_index <= 0.
  - Otherwise: cmp_idx++, cnt++. cnt wraps at DEPTH; the wrapped read is ignored.
- RESP: outputs stay stable while rsp_ready = 0. On `rsp_valid && rsp_ready`, go to IDLE.
- The first hit terminates the scan, so duplicate entries report the lowest index.
- Table writes landing during a scan are not tracked. Each entry is compared with whatever q shows in its compare cycle.
- Reset (asynchronous, any state including mid-scan): state=IDLE, cnt=0, cmp_idx=0, latched request cleared.
  - Outputs during and after reset: req_ready=1, rsp_valid=0, rsp_match=0, rsp_index=0, ram_addr=0.
  - A scan interrupted by reset produces no response.

## Timing
- Request accepted at edge E0.
- Entry k hits: rsp_valid rises after edge E(k+2). Entry 0 takes 2 cycles, entry 3 takes 5 cycles.
- Full miss: rsp_valid after E(DEPTH+1), i.e. 5 cycles at default.
- Invalid size: rsp_valid after E1.
- The earliest next accept is the edge after the response handshake. There is no overlap, so throughput is at most 1 lookup per (latency+1) cycles.
- `ram_addr` changes only on clock edges. It is glitch-free toward the table.
- No combinational path from req_* or rsp_ready to any output.

## Test plan
- Hit at entry 0:
  - Stimulus: table entry 0 = "ORDER", size 5 (0x4F52444552 left-justified, size byte 0x05). Request "ORDER"/5.
  - Required: rsp_valid 2 cycles after accept, rsp_match=1, rsp_index=0, ram_addr sequence 0,1.
- Last-entry hit and duplicate:
  - Stimulus: entries 1 and 3 = "HOSTB"/5, request "HOSTB"/5, rsp_index=1 expected. Then clear entry 1 to size 0 and repeat.
  - Required: first lookup gives rsp_index=1 at 3 cycles. Second lookup gives rsp_index=3 at 5 cycles.
- Prefix and size mismatch:
  - Stimulus: entry 0 = "ORDERS"/6, other entries size 0. Request "ORDER"/5 with trailing garbage 0xFF bytes.
  - Required: miss, rsp_index=0, 5 cycles.
- Invalid request sizes:
  - Stimulus: req_size = 0, and req_size = 10.
  - Required: miss after 1 cycle each; ram_addr stays 0.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 7 cycles after rsp_valid, while req_valid stays high with a new value.
  - Required: rsp_* stable, req_ready=0 throughout. The new request is accepted only on the cycle after the handshake.
- Reset mid-scan:
  - Stimulus: assert reset_n=0 asynchronously during SCAN (cmp_idx=2), release, then issue "ORDER"/5.
  - Required: no response to the aborted request; all outputs at reset values immediately. The new lookup behaves as in the first test.
